fifo_ctrl: RTL

Single-clock FIFO controller that sequences the team's dual-port `ram` block (`DATA_BITS` wide, 2^`ADDR_BITS` deep) as a synchronous FIFO. It owns the write and read pointers and the occupancy count, and drives the RAM's write enable, addresses and full-gate. It registers read data from the RAM's combinational read port and reports full, empty, almost-full and almost-empty status plus sticky error flags. It is the same-domain counterpart to the async FIFO and reuses the same RAM macro unchanged.

---
 rtl/fifo_ctrl_if.sv | 21 ++
 rtl/fifo_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/fifo_ctrl_if.sv
// Push/pop handshake bundle between a FIFO user and fifo_ctrl.
// The master drives requests and push data; the slave returns registered pop data.
interface fifo_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller sequencing a dual-port RAM with a combinational read port.
// Owns pointers, occupancy count, registered status flags and sticky overflow/underflow.
module fifo_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4,
  parameter int AF_LEVEL  = (1 << ADDR_BITS) - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  fifo_ctrl_if.slave           bus,
  output logic [DATA_BITS-1:0] ram_w_data,
  output logic [ADDR_BITS-1:0] ram_w_addr,
  output logic [ADDR_BITS-1:0] ram_r_addr,
  output logic                 ram_w_clk_en,
  output logic                 ram_w_full,
  input  logic [DATA_BITS-1:0] ram_r_data,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  localparam int                 DEPTH   = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AF_C    = (ADDR_BITS + 1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0] AE_C    = (ADDR_BITS + 1)'(AE_LEVEL);
  localparam logic [ADDR_BITS:0] ONE_C   = (ADDR_BITS + 1)'(1);

  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_almost_full;
  logic                 r_almost_empty;
  logic                 r_overflow;
  logic                 r_underflow;
  logic [DATA_BITS-1:0] r_rd_data;
  logic                 r_rd_valid;

  logic                 w_push;
  logic                 w_pop;
  logic [ADDR_BITS:0]   w_count_nxt;

  // Acceptance uses the registered flags, so a full FIFO rejects a push even if it pops.
  assign w_push = bus.wr_en && !r_full;
  assign w_pop  = bus.rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + ONE_C;
    else if (w_pop && !w_push)
      w_count_nxt = r_count - ONE_C;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_BITS'(1);
        r_rd_data <= ram_r_data;
      end
      r_rd_valid     <= w_pop;
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == DEPTH_C);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= AF_C);
      r_almost_empty <= (w_count_nxt <= AE_C);
      // Set beats clear when both happen in the same cycle.
      r_overflow     <= (r_overflow  && !clr_err) || (bus.wr_en && r_full);
      r_underflow    <= (r_underflow && !clr_err) || (bus.rd_en && r_empty);
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;

  assign ram_w_data   = bus.wr_data;
  assign ram_w_addr   = r_wr_ptr;
  assign ram_r_addr   = r_rd_ptr;
  assign ram_w_clk_en = bus.wr_en;
  // Reset blocks the RAM write since the push path is not gated by w_rst otherwise.
  assign ram_w_full   = r_full || w_rst;

  assign count        = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
